touch_adc_ctrl: RTL and testbench
=================================

TOUCH_ADC_CTRL -- requirements
Module: touch_adc_ctrl

Interface
REQ-001 Parameter CLK_DIV, default 25: sys_clk cycles per adc_dclk half-period (range 2..255).
REQ-002 Parameter DEB_CYCLES, default 1000: sys_clk cycles penirq_n must stay low before a touch is accepted.
REQ-003 Parameter GAP_CYCLES, default 5000: sys_clk cycles idle between X/Y pairs while the pen is down.
REQ-004 sys_clk  in  1  single system clock; all logic on its rising edge.
REQ-005 iRST_n  in  1  reset, asynchronous, active-low.
REQ-006 penirq_n  in  1  pen interrupt from the touch ADC, asynchronous, low = pen down.
REQ-007 adc_dout  in  1  serial data from the ADC.
REQ-008 adc_dclk  out  1  serial clock to the ADC, idle low.
REQ-009 adc_cs_n  out  1  ADC chip select, active-low.
REQ-010 adc_din  out  1  serial command to the ADC, MSB first.
REQ-011 x  out  8  last valid X coordinate.
REQ-012 y  out  8  last valid Y coordinate.
REQ-013 new_coord_r  out  1  one-cycle pulse when x/y are updated together.
REQ-014 transmit_en  out  1  high for the whole duration of an accepted touch.

Function
REQ-015 penirq_n shall pass through a 2-flop synchronizer before use; the raw input is never sampled directly.
REQ-016 FSM states shall be IDLE, DEBOUNCE, CONV_X, CONV_Y, PUBLISH, GAP.
REQ-017 IDLE->DEBOUNCE on synchronized penirq_n low; in DEBOUNCE, a high sample returns to IDLE and the counter clears.
REQ-018 DEBOUNCE->CONV_X after DEB_CYCLES consecutive low samples; transmit_en is set on that same transition.
REQ-019 Each conversion shall be one transfer of 24 adc_dclk periods with adc_cs_n low throughout.
REQ-020 adc_cs_n shall fall CLK_DIV cycles before the first dclk rising edge and rise CLK_DIV cycles after the last falling edge.
REQ-021 Command byte: X = 8'hD8, Y = 8'h98 (8-bit mode, differential, PD=00 so penirq stays enabled).
REQ-022 adc_din shall change on dclk falling edges during clocks 1-8, then hold 0.
REQ-023 adc_dout shall be sampled on the dclk rising edges of clocks 10-17, MSB first, into the 8-bit result.
REQ-024 CONV_X->CONV_Y->PUBLISH in sequence; x and y are latched to internal holding registers, not to the outputs.
REQ-025 In PUBLISH (1 cycle), x and y outputs shall update together, new_coord_r shall pulse for 1 cycle, and the FSM goes to GAP.
REQ-026 In GAP, adc_cs_n is high; after GAP_CYCLES, a synchronized penirq_n low goes to CONV_X, and high clears transmit_en and goes to IDLE.
REQ-027 penirq_n changes during CONV_X/CONV_Y shall be ignored; the current pair always completes.
REQ-028 x and y shall hold their values between touches; new_coord_r never pulses while transmit_en is low.

Reset
REQ-029 When iRST_n is low: FSM=IDLE, x=0, y=0, new_coord_r=0, transmit_en=0, adc_cs_n=1, adc_dclk=0, adc_din=0, all counters 0.
REQ-030 Reset mid-transfer shall abort immediately; adc_cs_n goes high asynchronously and no partial coordinate is published.

Configuration
REQ-031 Macro TOUCH_AVG_EN: when defined, each axis shall be converted twice back-to-back and the published value is (s0+s1+1)>>1, using 9-bit intermediate arithmetic.
REQ-032 Without TOUCH_AVG_EN, one conversion per axis shall be done and the raw 8-bit result is published.

Structure
REQ-033 Package touch_pkg shall hold the state enum, CMD_X/CMD_Y constants, and the transfer length (24) and sample window (10-17).
REQ-034 Sub-module touch_spi_xfer shall own dclk generation, the shift registers and cs timing, with a start/done handshake (done = 1-cycle pulse, result valid with done).

Verification
REQ-035 ADC model returns X=8'h5A, Y=8'hC3, pen held low -> one new_coord_r pulse per pair, x=8'h5A, y=8'hC3, and adc_din shows 8'hD8 then 8'h98.
REQ-036 penirq_n low for DEB_CYCLES-1 then high -> transmit_en stays 0 and adc_cs_n never falls.
REQ-037 Pen released during CONV_Y -> pair completes, then transmit_en falls after GAP_CYCLES with no further cs activity.
REQ-038 iRST_n asserted at dclk clock 12 of CONV_X -> adc_cs_n=1 in the same cycle; outputs at reset values; no new_coord_r pulse.
REQ-039 With TOUCH_AVG_EN, X samples 8'h10 and 8'h13 -> x=8'h12; X samples 8'hFF and 8'hFF -> x=8'hFF (no overflow).
REQ-040 CLK_DIV=2 -> adc_dclk period is 4 sys_clk, and each transfer is exactly 24 rising edges.

Source files
------------

// File: rtl/touch_pkg.sv
// Shared types and constants for the resistive touch ADC controller.
// States, ADC command bytes and serial transfer framing.
package touch_pkg;

  typedef enum logic [2:0] {
    IDLE,
    DEBOUNCE,
    CONV_X,
    CONV_Y,
    PUBLISH,
    GAP
  } state_t;

  typedef enum logic [1:0] {
    PH_IDLE,
    PH_SETUP,
    PH_CLKS,
    PH_HOLD
  } xfer_ph_t;

  // 8-bit mode, differential, PD=00 keeps penirq alive
  localparam logic [7:0] CMD_X = 8'hD8;
  localparam logic [7:0] CMD_Y = 8'h98;

  localparam int XFER_CLKS  = 24;
  localparam int SAMP_FIRST = 10;
  localparam int SAMP_LAST  = 17;

  function automatic logic [7:0] avg2(
    input logic [7:0] a,
    input logic [7:0] b
  );
    logic [8:0] s;
    s = {1'b0, a} + {1'b0, b} + 9'd1;
    return s[8:1];
  endfunction

endpackage

// File: rtl/touch_spi_xfer.sv
// One 24-clock serial transfer: cs framing, dclk, command out, result in.
// Start is accepted in idle; done pulses one cycle with the result valid.
module touch_spi_xfer
  import touch_pkg::*;
#(
  parameter int CLK_DIV = 25
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_start,
  input  logic [7:0] i_cmd,
  input  logic       i_dout,
  output logic       o_dclk,
  output logic       o_cs_n,
  output logic       o_din,
  output logic       o_done,
  output logic [7:0] o_result
);

  localparam logic [7:0] DIV_MAX = 8'(CLK_DIV - 1);

  xfer_ph_t   r_ph;
  xfer_ph_t   w_ph_nxt;
  logic [7:0] r_div;
  logic [4:0] r_clk;
  logic       r_dclk;
  logic       r_cs_n;
  logic [7:0] r_sh;
  logic [7:0] r_res;
  logic       r_done;

  logic       w_tick;
  logic       w_rise;
  logic       w_fall;
  logic [4:0] w_clk_nx;
  logic       w_in_win;

  assign w_tick   = (r_div == DIV_MAX);
  assign w_rise   = w_tick && !r_dclk &&
                    (r_ph == PH_CLKS || r_ph == PH_SETUP);
  assign w_fall   = w_tick && r_dclk && (r_ph == PH_CLKS);
  assign w_clk_nx = r_clk + 5'd1;
  assign w_in_win = (w_clk_nx >= 5'(SAMP_FIRST)) &&
                    (w_clk_nx <= 5'(SAMP_LAST));

  always_comb begin
    w_ph_nxt = r_ph;
    unique case (r_ph)
      PH_IDLE:  if (i_start) w_ph_nxt = PH_SETUP;
      PH_SETUP: if (w_tick) w_ph_nxt = PH_CLKS;
      PH_CLKS:
        if (w_fall && r_clk == 5'(XFER_CLKS))
          w_ph_nxt = PH_HOLD;
      PH_HOLD:  if (w_tick) w_ph_nxt = PH_IDLE;
      default:  w_ph_nxt = PH_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ph   <= PH_IDLE;
      r_div  <= '0;
      r_clk  <= '0;
      r_dclk <= 1'b0;
      r_cs_n <= 1'b1;
      r_sh   <= '0;
      r_res  <= '0;
      r_done <= 1'b0;
    end else begin
      r_ph   <= w_ph_nxt;
      r_done <= (r_ph == PH_HOLD) && w_tick;
      if (r_ph == PH_IDLE || w_tick)
        r_div <= '0;
      else
        r_div <= r_div + 8'd1;
      if (r_ph == PH_IDLE && i_start) begin
        r_cs_n <= 1'b0;
        r_sh   <= i_cmd;
        r_res  <= '0;
        r_clk  <= '0;
      end
      if (r_ph == PH_HOLD && w_tick)
        r_cs_n <= 1'b1;
      if (w_rise) begin
        r_dclk <= 1'b1;
        r_clk  <= w_clk_nx;
        if (w_in_win)
          r_res <= {r_res[6:0], i_dout};
      end
      // zero fill leaves din low once the command is out
      if (w_fall) begin
        r_dclk <= 1'b0;
        r_sh   <= {r_sh[6:0], 1'b0};
      end
    end
  end

  assign o_dclk   = r_dclk;
  assign o_cs_n   = r_cs_n;
  assign o_din    = r_sh[7];
  assign o_done   = r_done;
  assign o_result = r_res;

endmodule

// File: rtl/touch_adc_ctrl.sv
// Touch screen ADC controller: debounce, X/Y conversion, paired publish.
// TOUCH_AVG_EN: convert each axis twice and publish the rounded mean.
module touch_adc_ctrl
  import touch_pkg::*;
#(
  parameter int CLK_DIV    = 25,
  parameter int DEB_CYCLES = 1000,
  parameter int GAP_CYCLES = 5000
) (
  input  logic       sys_clk,
  input  logic       iRST_n,
  input  logic       penirq_n,
  input  logic       adc_dout,
  output logic       adc_dclk,
  output logic       adc_cs_n,
  output logic       adc_din,
  output logic [7:0] x,
  output logic [7:0] y,
  output logic       new_coord_r,
  output logic       transmit_en
);

  localparam int DW = $clog2(DEB_CYCLES + 1);
  localparam int GW = $clog2(GAP_CYCLES + 1);

  state_t        r_state;
  state_t        w_next;
  logic          r_pen_s1;
  logic          r_pen_s2;
  logic [DW-1:0] r_deb;
  logic [GW-1:0] r_gap;
  logic          r_active;
  logic [7:0]    r_x_hold;
  logic [7:0]    r_y_hold;
  logic [7:0]    r_x;
  logic [7:0]    r_y;
  logic          r_new;
  logic          r_ten;

  logic          w_pen_dn;
  logic          w_conv;
  logic          w_start;
  logic [7:0]    w_cmd;
  logic          w_done;
  logic [7:0]    w_res;
  logic          w_last;
  logic [7:0]    w_val;

  assign w_pen_dn = !r_pen_s2;
  assign w_conv   = (r_state == CONV_X) || (r_state == CONV_Y);
  assign w_start  = w_conv && !r_active;
  assign w_cmd    = (r_state == CONV_Y) ? CMD_Y : CMD_X;

  touch_spi_xfer #(
    .CLK_DIV (CLK_DIV)
  ) u_xfer (
    .i_clk    (sys_clk),
    .i_rst_n  (iRST_n),
    .i_start  (w_start),
    .i_cmd    (w_cmd),
    .i_dout   (adc_dout),
    .o_dclk   (adc_dclk),
    .o_cs_n   (adc_cs_n),
    .o_din    (adc_din),
    .o_done   (w_done),
    .o_result (w_res)
  );

`ifdef TOUCH_AVG_EN
  logic       r_samp;
  logic [7:0] r_s0;

  assign w_last = r_samp;
  assign w_val  = avg2(r_s0, w_res);

  always_ff @(posedge sys_clk or negedge iRST_n) begin
    if (!iRST_n) begin
      r_samp <= 1'b0;
      r_s0   <= '0;
    end else if (w_done) begin
      r_samp <= !r_samp;
      if (!r_samp)
        r_s0 <= w_res;
    end
  end
`else
  assign w_last = 1'b1;
  assign w_val  = w_res;
`endif

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE:
        if (w_pen_dn) w_next = DEBOUNCE;
      DEBOUNCE:
        if (!w_pen_dn)
          w_next = IDLE;
        else if (r_deb == DW'(DEB_CYCLES - 1))
          w_next = CONV_X;
      CONV_X:
        if (w_done && w_last) w_next = CONV_Y;
      CONV_Y:
        if (w_done && w_last) w_next = PUBLISH;
      PUBLISH:
        w_next = GAP;
      GAP:
        if (r_gap == GW'(GAP_CYCLES - 1))
          w_next = w_pen_dn ? CONV_X : IDLE;
      default:
        w_next = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge iRST_n) begin
    if (!iRST_n) begin
      r_state  <= IDLE;
      r_pen_s1 <= 1'b1;
      r_pen_s2 <= 1'b1;
      r_deb    <= '0;
      r_gap    <= '0;
      r_active <= 1'b0;
      r_x_hold <= '0;
      r_y_hold <= '0;
      r_x      <= '0;
      r_y      <= '0;
      r_new    <= 1'b0;
      r_ten    <= 1'b0;
    end else begin
      r_state  <= w_next;
      r_pen_s1 <= penirq_n;
      r_pen_s2 <= r_pen_s1;
      r_new    <= (r_state == PUBLISH);
      if (r_state == DEBOUNCE && w_next == DEBOUNCE)
        r_deb <= r_deb + DW'(1);
      else
        r_deb <= '0;
      if (r_state == GAP && w_next == GAP)
        r_gap <= r_gap + GW'(1);
      else
        r_gap <= '0;
      if (w_start)
        r_active <= 1'b1;
      else if (w_done)
        r_active <= 1'b0;
      if (w_done && w_last) begin
        if (r_state == CONV_X)
          r_x_hold <= w_val;
        else
          r_y_hold <= w_val;
      end
      // both axes move to the outputs on the same edge
      if (r_state == PUBLISH) begin
        r_x <= r_x_hold;
        r_y <= r_y_hold;
      end
      if (r_state == DEBOUNCE && w_next == CONV_X)
        r_ten <= 1'b1;
      else if (r_state == GAP && w_next == IDLE)
        r_ten <= 1'b0;
    end
  end

  assign x           = r_x;
  assign y           = r_y;
  assign new_coord_r = r_new;
  assign transmit_en = r_ten;

endmodule

// File: tb/tb_touch_adc_ctrl.sv
// Bench for touch_adc_ctrl: ADC model, serial monitor and scoreboard.
// Build with +define+TOUCH_AVG_EN to exercise the averaging variant.
module tb_touch_adc_ctrl;

  localparam int CLK_DIV = 2;
  localparam int DEB     = 8;
  localparam int GAP     = 20;
`ifdef TOUCH_AVG_EN
  localparam int NCONV = 2;
`else
  localparam int NCONV = 1;
`endif

  logic       sys_clk;
  logic       iRST_n;
  logic       penirq_n;
  logic       adc_dout;
  logic       adc_dclk;
  logic       adc_cs_n;
  logic       adc_din;
  logic [7:0] x;
  logic [7:0] y;
  logic       new_coord_r;
  logic       transmit_en;

  touch_adc_ctrl #(
    .CLK_DIV    (CLK_DIV),
    .DEB_CYCLES (DEB),
    .GAP_CYCLES (GAP)
  ) dut (
    .sys_clk     (sys_clk),
    .iRST_n      (iRST_n),
    .penirq_n    (penirq_n),
    .adc_dout    (adc_dout),
    .adc_dclk    (adc_dclk),
    .adc_cs_n    (adc_cs_n),
    .adc_din     (adc_din),
    .x           (x),
    .y           (y),
    .new_coord_r (new_coord_r),
    .transmit_en (transmit_en)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  typedef struct {
    logic [7:0] xa, xb, ya, yb;
    logic [7:0] ex_raw, ey_raw;
    logic [7:0] ex_avg, ey_avg;
  } vec_t;

  vec_t tbl[5];

  logic [7:0]  cq[$];
  logic [15:0] pq[$];

  logic [7:0] mxa, mxb, mya, myb;
  int  checks = 0;
  int  errors = 0;
  int  tmo = 0;
  bit  fin = 0;
  bit  no_touch = 0;

  // ADC model: latch command on rises 1-8, shift result on falls 9-16
  int         m_r, m_f;
  logic [7:0] m_cmd, m_v;
  bit         m_pd, sx, sy;
  initial begin
    adc_dout = 1'b0;
    m_r = 0; m_f = 0; m_cmd = 0; m_v = 0;
    m_pd = 0; sx = 0; sy = 0;
  end
  always @(negedge sys_clk) begin
    if (adc_cs_n) begin
      m_r = 0; m_f = 0; m_cmd = 0;
      adc_dout = 1'b0;
    end else begin
      if (!m_pd && adc_dclk) begin
        m_r++;
        if (m_r <= 8) m_cmd = {m_cmd[6:0], adc_din};
      end
      if (m_pd && !adc_dclk) begin
        m_f++;
        if (m_f == 9) begin
          if (m_cmd == 8'hD8) begin
            m_v = sx ? mxb : mxa; sx = ~sx;
          end else begin
            m_v = sy ? myb : mya; sy = ~sy;
          end
        end
        if (m_f >= 9 && m_f <= 16)
          adc_dout = m_v[3'(16 - m_f)];
        else
          adc_dout = 1'b0;
      end
    end
    if (!transmit_en) begin sx = 0; sy = 0; end
    m_pd = adc_dclk;
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h want 0x%0h @%0t",
               nm, act, exp, $time);
    end
  endtask

  // all comparisons live in this one process
  int cyc = 0, rises = 0, cs_falls = 0, coord_seen = 0;
  int t_cs, t_rise, t_fall, t_new;
  bit p_cs = 1, p_dclk = 0, p_new = 0, p_ten = 0, gap_arm = 0;
  logic [7:0]  cmd_sh, e8;
  logic [15:0] e16;
  always @(negedge sys_clk) begin
    cyc++;
    if (fin) begin
      chk("cmd_queue_left", cq.size(), 0);
      chk("coord_queue_left", pq.size(), 0);
      chk("timeouts", tmo, 0);
      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
    end else if (!iRST_n) begin
      chk("rst_cs_n", int'(adc_cs_n), 1);
      chk("rst_dclk", int'(adc_dclk), 0);
      chk("rst_din", int'(adc_din), 0);
      chk("rst_x", int'(x), 0);
      chk("rst_y", int'(y), 0);
      chk("rst_new", int'(new_coord_r), 0);
      chk("rst_ten", int'(transmit_en), 0);
      p_cs = 1; p_dclk = 0; p_new = 0; p_ten = 0;
      rises = 0; gap_arm = 0;
    end else begin
      if (p_cs && !adc_cs_n) begin
        cs_falls++;
        chk("cs_fall_ten", int'(transmit_en), 1);
        rises = 0; t_cs = cyc; cmd_sh = 0;
      end
      if (!p_dclk && adc_dclk) begin
        rises++;
        if (rises == 1) chk("cs_setup", cyc - t_cs, CLK_DIV);
        else chk("dclk_period", cyc - t_rise, 2 * CLK_DIV);
        t_rise = cyc;
        if (rises <= 8) cmd_sh = {cmd_sh[6:0], adc_din};
        if (rises == 8) begin
          if (cq.size() == 0) chk("cmd_avail", cq.size(), 1);
          else begin
            e8 = cq.pop_front();
            chk("cmd_byte", int'(cmd_sh), int'(e8));
          end
        end
      end
      if (p_dclk && !adc_dclk) t_fall = cyc;
      if (!p_cs && adc_cs_n) begin
        chk("dclk_rises", rises, 24);
        chk("cs_hold", cyc - t_fall, CLK_DIV);
      end
      if (new_coord_r) begin
        chk("new_ten", int'(transmit_en), 1);
        chk("new_width", int'(p_new), 0);
        if (pq.size() == 0) chk("coord_avail", pq.size(), 1);
        else begin
          e16 = pq.pop_front();
          chk("x", int'(x), int'(e16[15:8]));
          chk("y", int'(y), int'(e16[7:0]));
        end
        coord_seen++; t_new = cyc; gap_arm = 1;
      end
      if (p_ten && !transmit_en) begin
        if (gap_arm) chk("gap_len", cyc - t_new, GAP);
        gap_arm = 0;
      end
      if (no_touch) begin
        chk("deb_ten", int'(transmit_en), 0);
        chk("deb_cs", int'(adc_cs_n), 1);
      end
      p_cs = adc_cs_n; p_dclk = adc_dclk;
      p_new = new_coord_r; p_ten = transmit_en;
    end
  end

  task automatic push_pair(input logic [7:0] ex, input logic [7:0] ey);
    for (int j = 0; j < NCONV; j++) cq.push_back(8'hD8);
    for (int j = 0; j < NCONV; j++) cq.push_back(8'h98);
    pq.push_back({ex, ey});
  endtask

  task automatic wait_coords(input int n);
    int s;
    s = coord_seen;
    for (int i = 0; i < 5000 && coord_seen < s + n; i++)
      @(negedge sys_clk);
    if (coord_seen < s + n) begin
      tmo++;
      $display("FAIL timeout coord: got %0d want %0d",
               coord_seen - s, n);
    end
  endtask

  task automatic wait_ten_low();
    for (int i = 0; i < 5000 && transmit_en; i++)
      @(negedge sys_clk);
    if (transmit_en) begin
      tmo++;
      $display("FAIL timeout ten_low: got 1 want 0");
    end
  endtask

  task automatic set_model(input logic [7:0] xa, input logic [7:0] xb,
                           input logic [7:0] ya, input logic [7:0] yb);
    mxa = xa; mxb = xb; mya = ya; myb = yb;
  endtask

  initial begin
    int base, cnt;
    bit pd;
    logic [7:0] ex, ey;
    tbl[0] = '{8'h5A, 8'h5A, 8'hC3, 8'hC3, 8'h5A, 8'hC3, 8'h5A, 8'hC3};
    tbl[1] = '{8'h10, 8'h13, 8'hFF, 8'hFF, 8'h10, 8'hFF, 8'h12, 8'hFF};
    tbl[2] = '{8'hFF, 8'hFF, 8'h00, 8'h01, 8'hFF, 8'h00, 8'hFF, 8'h01};
    tbl[3] = '{8'h00, 8'h00, 8'h80, 8'h7F, 8'h00, 8'h80, 8'h00, 8'h80};
    tbl[4] = '{8'h81, 8'h7E, 8'h3C, 8'h3C, 8'h81, 8'h3C, 8'h80, 8'h3C};
    set_model(0, 0, 0, 0);
    penirq_n = 1'b1;
    iRST_n = 1'b0;
    repeat (4) @(negedge sys_clk);
    iRST_n = 1'b1;
    repeat (4) @(negedge sys_clk);

    foreach (tbl[i]) begin
      set_model(tbl[i].xa, tbl[i].xb, tbl[i].ya, tbl[i].yb);
`ifdef TOUCH_AVG_EN
      ex = tbl[i].ex_avg; ey = tbl[i].ey_avg;
`else
      ex = tbl[i].ex_raw; ey = tbl[i].ey_raw;
`endif
      push_pair(ex, ey);
      penirq_n = 1'b0;
      wait_coords(1);
      penirq_n = 1'b1;
      wait_ten_low();
      repeat (5) @(negedge sys_clk);
    end

    // pen held: two back-to-back pairs
    set_model(8'h5A, 8'h5A, 8'hC3, 8'hC3);
    push_pair(8'h5A, 8'hC3);
    push_pair(8'h5A, 8'hC3);
    penirq_n = 1'b0;
    wait_coords(2);
    penirq_n = 1'b1;
    wait_ten_low();
    repeat (5) @(negedge sys_clk);

    // short press must be rejected
    no_touch = 1;
    penirq_n = 1'b0;
    repeat (DEB - 1) @(negedge sys_clk);
    penirq_n = 1'b1;
    repeat (30) @(negedge sys_clk);
    no_touch = 0;

    // release during the Y conversion
    set_model(8'h3C, 8'h3C, 8'hE1, 8'hE1);
    push_pair(8'h3C, 8'hE1);
    base = cs_falls;
    penirq_n = 1'b0;
    for (int i = 0; i < 5000 && cs_falls < base + NCONV + 1; i++)
      @(negedge sys_clk);
    if (cs_falls < base + NCONV + 1) begin
      tmo++;
      $display("FAIL timeout conv_y: got %0d want %0d",
               cs_falls - base, NCONV + 1);
    end
    penirq_n = 1'b1;
    wait_coords(1);
    wait_ten_low();
    repeat (60) @(negedge sys_clk);

    // reset at dclk clock 12 of the X conversion
    set_model(8'h77, 8'h77, 8'h88, 8'h88);
    cq.push_back(8'hD8);
    penirq_n = 1'b0;
    cnt = 0;
    pd = adc_dclk;
    for (int i = 0; i < 5000 && cnt < 12; i++) begin
      @(posedge sys_clk);
      #1;
      if (!pd && adc_dclk && !adc_cs_n) cnt++;
      pd = adc_dclk;
    end
    if (cnt < 12) begin
      tmo++;
      $display("FAIL timeout clk12: got %0d want 12", cnt);
    end
    iRST_n = 1'b0;
    repeat (3) @(negedge sys_clk);
    penirq_n = 1'b1;
    repeat (3) @(negedge sys_clk);
    iRST_n = 1'b1;
    repeat (400) @(negedge sys_clk);

    fin = 1;
  end

endmodule
